cache_opr_resp: RTL and testbench
=================================

CACHE_OPR_RESP -- requirements
Module: cache_opr_resp

Interface
REQ-001 Parameter NUM_OPR, default 8: number of serial cache operations tracked.
REQ-002 Parameter OP_TIMEOUT, default 16: maximum cycles from stage_go to stage_ack.
REQ-003 clk  in  1  clock, all state on rising edge.
REQ-004 rstb  in  1  reset, asynchronous, active-low.
REQ-005 opr_start  in  NUM_OPR  single-cycle start strobes from the operation sequencer; bit i means start operation i+1.
REQ-006 stage_ack  in  NUM_OPR  single-cycle completion strobes from the datapath stages.
REQ-007 abort  in  1  synchronous clear of the error state.
REQ-008 stage_go  out  NUM_OPR  one-hot single-cycle launch strobe to the datapath stage.
REQ-009 cur_opr  out  3  index of the active or last-completed operation.
REQ-010 done_mask  out  NUM_OPR  sticky set of completed operations in the current sequence.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 opr_finished  out  1  single-cycle pulse when operation NUM_OPR completes; this pulse is the sequencer's opr_finished input.
REQ-013 seq_err, timeout_err  out  1 each  sticky error flags.

Function
REQ-014 The FSM SHALL have five states: IDLE, WAIT_ACK, ARMED, FINISH and ERROR.
REQ-015 In IDLE, opr_start == 1 (bit 0 only) SHALL set cur_opr=0, clear done_mask and the timer, and move the FSM to WAIT_ACK.
REQ-016 In IDLE, any other opr_start value SHALL be ignored, with no error.
REQ-017 stage_go[cur_opr] SHALL be registered and pulse for exactly one cycle, the cycle after the accepted start strobe is sampled.
REQ-018 In WAIT_ACK, the timer SHALL increment each cycle.
REQ-019 In WAIT_ACK, stage_ack[cur_opr] SHALL set done_mask[cur_opr]; the FSM SHALL go to FINISH if cur_opr==NUM_OPR-1, otherwise to ARMED.
REQ-020 In WAIT_ACK, stage_ack bits other than cur_opr SHALL be ignored.
REQ-021 In WAIT_ACK, a timer value of OP_TIMEOUT-1 with no ack SHALL set timeout_err and move the FSM to ERROR.
REQ-022 If ack and timeout occur in the same cycle, the ack SHALL win.
REQ-023 In WAIT_ACK, any nonzero opr_start SHALL set seq_err and move the FSM to ERROR.
REQ-024 In ARMED, opr_start equal to exactly bit cur_opr+1 SHALL increment cur_opr, clear the timer, launch stage_go as in REQ-017, and move the FSM to WAIT_ACK.
REQ-025 In ARMED, any other nonzero opr_start (wrong bit or multi-hot) SHALL set seq_err and move the FSM to ERROR.
REQ-026 In ARMED, zero opr_start SHALL hold state; there is no timeout in ARMED.
REQ-027 FINISH SHALL last one cycle, assert opr_finished during that cycle, and return to IDLE; done_mask SHALL hold all-ones until the next accepted start.
REQ-028 opr_finished SHALL therefore rise exactly one cycle after the final stage_ack is sampled.
REQ-029 ERROR SHALL hold until abort=1, then clear seq_err, timeout_err and done_mask, and return to IDLE.
REQ-030 In any state other than ERROR, abort SHALL force IDLE.
REQ-031 The timer SHALL be $clog2(OP_TIMEOUT)+1 bits wide and saturate; it SHALL never wrap.
REQ-032 cur_opr SHALL never exceed NUM_OPR-1.

Reset
REQ-033 On rstb=0: state=IDLE; cur_opr=0; done_mask=0; stage_go=0; opr_finished=0; seq_err=0; timeout_err=0; timer=0.
REQ-034 busy SHALL be 0 while rstb=0.
REQ-035 Reset asserted mid-sequence SHALL abandon the sequence with no opr_finished pulse.

Structure
REQ-036 Package cache_opr_pkg SHALL hold NUM_OPR, OP_TIMEOUT and the state enum opr_resp_state_t, shared with the sequencer.
REQ-037 The timeout counter SHALL be the sub-module opr_timer, with inputs clr and en and output expired.

Verification
REQ-038 Full sequence: start bits 0..7 issued 4 cycles apart, ack 2 cycles after each stage_go -> stage_go pulses in order 0..7, done_mask=8'hFF, one opr_finished pulse one cycle after the 8th ack, seq_err=0.
REQ-039 Timeout: start bit 0 then no ack -> timeout_err=1 and ERROR reached 16 cycles after stage_go[0]; abort -> IDLE with both flags at 0.
REQ-040 Order violation: after op 1 completes, opr_start=8'h04 -> seq_err=1, no stage_go, busy stays 1.
REQ-041 Ack/timeout collision: ack on timer count 15 -> done_mask[0]=1, timeout_err=0.
REQ-042 Reset mid-run: rstb low during op 4 WAIT_ACK -> all outputs 0 immediately; a new start 8'h01 is accepted normally.
REQ-043 Stray inputs: stage_ack[5] during op 2, and opr_start=8'h02 in IDLE -> both ignored, no error.

Source files
------------

// File: rtl/cache_opr_pkg.sv
// rtl/cache_opr_pkg.sv - shared constants and FSM state type for the cache operation responder
package cache_opr_pkg;

  localparam int NUM_OPR    = 8;
  localparam int OP_TIMEOUT = 16;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_ACK = 3'd1,
    ARMED    = 3'd2,
    FINISH   = 3'd3,
    ERROR    = 3'd4
  } opr_resp_state_t;

endpackage

// File: rtl/opr_timer.sv
// rtl/opr_timer.sv - saturating per-operation ack timer
module opr_timer import cache_opr_pkg::*; #(
  parameter int TIMEOUT = OP_TIMEOUT
) (
  input  logic clk,
  input  logic rstb,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT) + 1;

  logic [W-1:0] count;

  // Holds at all-ones so a stalled operation can never wrap back to zero.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == W'(TIMEOUT - 1));

endmodule

// File: rtl/cache_opr_resp.sv
// rtl/cache_opr_resp.sv - tracks serial cache operations from start strobe through stage ack
module cache_opr_resp
  import cache_opr_pkg::opr_resp_state_t, cache_opr_pkg::IDLE, cache_opr_pkg::WAIT_ACK,
         cache_opr_pkg::ARMED, cache_opr_pkg::FINISH, cache_opr_pkg::ERROR;
#(
  parameter int NUM_OPR    = cache_opr_pkg::NUM_OPR,
  parameter int OP_TIMEOUT = cache_opr_pkg::OP_TIMEOUT
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic [NUM_OPR-1:0] opr_start,
  input  logic [NUM_OPR-1:0] stage_ack,
  input  logic               abort,
  output logic [NUM_OPR-1:0] stage_go,
  output logic [2:0]         cur_opr,
  output logic [NUM_OPR-1:0] done_mask,
  output logic               busy,
  output logic               opr_finished,
  output logic               seq_err,
  output logic               timeout_err
);

  localparam logic [NUM_OPR-1:0] ONE  = NUM_OPR'(1);
  localparam logic [2:0]         LAST = 3'(NUM_OPR - 1);

  opr_resp_state_t    state, state_nxt;
  logic [2:0]         cur_nxt;
  logic [NUM_OPR-1:0] mask_nxt, go_nxt;
  logic               seq_nxt, to_nxt;
  logic               tmr_clr, tmr_en, tmr_expired;

  opr_timer #(.TIMEOUT(OP_TIMEOUT)) u_timer (
    .clk     (clk),
    .rstb    (rstb),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state       <= IDLE;
      cur_opr     <= '0;
      done_mask   <= '0;
      stage_go    <= '0;
      seq_err     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      cur_opr     <= cur_nxt;
      done_mask   <= mask_nxt;
      stage_go    <= go_nxt;
      seq_err     <= seq_nxt;
      timeout_err <= to_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cur_nxt   = cur_opr;
    mask_nxt  = done_mask;
    go_nxt    = '0;
    seq_nxt   = seq_err;
    to_nxt    = timeout_err;
    tmr_clr   = 1'b0;
    tmr_en    = 1'b0;
    case (state)
      IDLE: begin
        if (!abort && (opr_start == ONE)) begin
          cur_nxt   = '0;
          mask_nxt  = '0;
          tmr_clr   = 1'b1;
          go_nxt    = ONE;
          state_nxt = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        tmr_en = 1'b1;
        // A start strobe mid-operation outranks a simultaneous ack; an ack outranks expiry.
        if (abort) begin
          state_nxt = IDLE;
        end else if (opr_start != '0) begin
          seq_nxt   = 1'b1;
          state_nxt = ERROR;
        end else if (stage_ack[cur_opr]) begin
          mask_nxt[cur_opr] = 1'b1;
          state_nxt = (cur_opr == LAST) ? FINISH : ARMED;
        end else if (tmr_expired) begin
          to_nxt    = 1'b1;
          state_nxt = ERROR;
        end
      end
      ARMED: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (opr_start == (ONE << (cur_opr + 3'd1))) begin
          cur_nxt   = cur_opr + 3'd1;
          tmr_clr   = 1'b1;
          go_nxt    = ONE << (cur_opr + 3'd1);
          state_nxt = WAIT_ACK;
        end else if (opr_start != '0) begin
          seq_nxt   = 1'b1;
          state_nxt = ERROR;
        end
      end
      FINISH: begin
        state_nxt = IDLE;
      end
      ERROR: begin
        if (abort) begin
          seq_nxt   = 1'b0;
          to_nxt    = 1'b0;
          mask_nxt  = '0;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy         = (state != IDLE);
  assign opr_finished = (state == FINISH);

endmodule

// File: tb/tb_cache_opr_resp.sv
// tb/tb_cache_opr_resp.sv - self-checking bench for cache_opr_resp
module tb_cache_opr_resp;

  localparam int N  = 8;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rstb;
  logic [N-1:0] opr_start, stage_ack, stage_go, done_mask;
  logic         abort, busy, opr_finished, seq_err, timeout_err;
  logic [2:0]   cur_opr;

  int n_cmp = 0;
  int n_bad = 0;
  int fin_pulses = 0;

  bit         m_active, m_wait, m_fin, m_err, m_seq, m_to;
  int         m_op, m_age;
  logic [7:0] m_mask, m_go;

  cache_opr_resp #(.NUM_OPR(N), .OP_TIMEOUT(TO)) dut (
    .clk          (clk),
    .rstb         (rstb),
    .opr_start    (opr_start),
    .stage_ack    (stage_ack),
    .abort        (abort),
    .stage_go     (stage_go),
    .cur_opr      (cur_opr),
    .done_mask    (done_mask),
    .busy         (busy),
    .opr_finished (opr_finished),
    .seq_err      (seq_err),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_wait = 0; m_fin = 0; m_err = 0; m_seq = 0; m_to = 0;
    m_op = 0; m_age = 0; m_mask = '0; m_go = '0;
  endtask

  // Protocol-level view: one operation in flight, the next one must be the next bit up.
  task automatic model_clock(input logic [7:0] s, input logic [7:0] a, input logic ab);
    logic [7:0] want;
    m_go = '0;
    if (m_err) begin
      if (ab) begin m_err = 0; m_seq = 0; m_to = 0; m_mask = '0; end
    end else if (ab) begin
      m_active = 0; m_wait = 0; m_fin = 0;
    end else if (m_fin) begin
      m_fin = 0;
    end else if (!m_active) begin
      if (s == 8'h01) begin
        m_active = 1; m_wait = 1; m_op = 0; m_age = 0; m_mask = '0; m_go = 8'h01;
      end
    end else if (m_wait) begin
      if (s != 0) begin
        m_seq = 1; m_err = 1; m_active = 0; m_wait = 0;
      end else if (a[m_op]) begin
        m_mask[m_op] = 1'b1;
        m_wait = 0;
        if (m_op == N - 1) begin m_active = 0; m_fin = 1; end
      end else if (m_age == TO - 1) begin
        m_to = 1; m_err = 1; m_active = 0; m_wait = 0;
      end else begin
        m_age++;
      end
    end else begin
      want = 8'(1 << (m_op + 1));
      if (s == want) begin
        m_op++; m_wait = 1; m_age = 0; m_go = want;
      end else if (s != 0) begin
        m_seq = 1; m_err = 1; m_active = 0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".busy"},     32'(busy),         32'(m_active | m_fin | m_err));
    check({tag, ".cur_opr"},  32'(cur_opr),      32'(m_op));
    check({tag, ".mask"},     32'(done_mask),    32'(m_mask));
    check({tag, ".go"},       32'(stage_go),     32'(m_go));
    check({tag, ".fin"},      32'(opr_finished), 32'(m_fin));
    check({tag, ".seq_err"},  32'(seq_err),      32'(m_seq));
    check({tag, ".to_err"},   32'(timeout_err),  32'(m_to));
    if (opr_finished) fin_pulses++;
  endtask

  task automatic step(input logic [7:0] s, input logic [7:0] a, input logic ab, input string tag);
    opr_start = s; stage_ack = a; abort = ab;
    @(posedge clk);
    model_clock(s, a, ab);
    #1;
    check_all(tag);
    opr_start = '0; stage_ack = '0; abort = 1'b0;
  endtask

  initial begin
    logic [7:0] rs, ra;
    logic       rab;
    int         r;

    rstb = 1'b0; opr_start = '0; stage_ack = '0; abort = 1'b0;
    model_reset();
    #2;
    check_all("reset");
    @(negedge clk);
    rstb = 1'b1;

    // Stray start in IDLE, then a full in-order sequence with a stray ack during op 2.
    step(8'h02, 8'h00, 1'b0, "idle_stray");
    fin_pulses = 0;
    for (int i = 0; i < N; i++) begin
      step(8'(1 << i), 8'h00, 1'b0, "seq_start");
      check("seq_go_order", 32'(stage_go), 32'(1 << i));
      step(8'h00, (i == 1) ? 8'h20 : 8'h00, 1'b0, "seq_gap");
      step(8'h00, 8'(1 << i), 1'b0, "seq_ack");
      if (i == N - 1) check("fin_after_last_ack", 32'(opr_finished), 32'd1);
      step(8'h00, 8'h00, 1'b0, "seq_post");
    end
    check("seq_mask_full", 32'(done_mask), 32'hFF);
    check("seq_fin_once", 32'(fin_pulses), 32'd1);
    check("seq_no_err", 32'(seq_err), 32'd0);

    // Timeout with no ack, then abort.
    step(8'h01, 8'h00, 1'b0, "to_start");
    for (int j = 1; j <= TO; j++) begin
      step(8'h00, 8'h00, 1'b0, "to_wait");
      if (j == TO - 1) check("to_not_yet", 32'(timeout_err), 32'd0);
    end
    check("to_flag", 32'(timeout_err), 32'd1);
    step(8'h00, 8'h00, 1'b1, "to_abort");
    check("to_abort_idle", 32'({busy, seq_err, timeout_err}), 32'd0);

    // Ack lands on the last timer count.
    step(8'h01, 8'h00, 1'b0, "coll_start");
    for (int j = 1; j < TO; j++) step(8'h00, 8'h00, 1'b0, "coll_wait");
    step(8'h00, 8'h01, 1'b0, "coll_ack");
    check("coll_mask0", 32'(done_mask[0]), 32'd1);
    check("coll_no_to", 32'(timeout_err), 32'd0);
    step(8'h00, 8'h00, 1'b1, "coll_abort");

    // Order violation after op 1 completes.
    step(8'h01, 8'h00, 1'b0, "ord_start");
    step(8'h00, 8'h01, 1'b0, "ord_ack");
    step(8'h00, 8'h00, 1'b0, "ord_armed");
    step(8'h04, 8'h00, 1'b0, "ord_bad");
    check("ord_seq_err", 32'(seq_err), 32'd1);
    check("ord_no_go", 32'(stage_go), 32'd0);
    check("ord_busy", 32'(busy), 32'd1);
    step(8'h00, 8'h00, 1'b1, "ord_abort");

    // Reset while op 4 waits for its ack, then a fresh start.
    step(8'h01, 8'h00, 1'b0, "rst_start");
    for (int k = 0; k < 3; k++) begin
      step(8'h00, 8'(1 << k), 1'b0, "rst_ack");
      step(8'(1 << (k + 1)), 8'h00, 1'b0, "rst_next");
    end
    step(8'h00, 8'h00, 1'b0, "rst_wait");
    #2 rstb = 1'b0;
    #1;
    model_reset();
    check_all("rst_mid");
    @(negedge clk);
    rstb = 1'b1;
    step(8'h01, 8'h00, 1'b0, "rst_restart");
    check("rst_restart_go", 32'(stage_go), 32'd1);

    // Randomized traffic biased towards legal progress.
    for (int c = 0; c < 400; c++) begin
      r = $urandom_range(0, 99);
      if (r < 10)      rs = 8'h01;
      else if (r < 40) rs = 8'(1 << ((m_op + 1) % N));
      else if (r < 45) rs = 8'($urandom);
      else             rs = 8'h00;
      r = $urandom_range(0, 3);
      if (r == 0)      ra = 8'(1 << m_op);
      else if (r == 1) ra = 8'($urandom);
      else             ra = 8'h00;
      rab = ($urandom_range(0, 49) == 0);
      step(rs, ra, rab, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
